// File: rtl/display_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg
// Shared constants for the multiplexed seven-segment display driver.
//   - SEG_*  : active-low glyphs, bit order {g,f,e,d,c,b,a}
//   - DIG_*  : scan index of each BCD digit (also its anode bit position)
// ----------------------------------------------------------------------------
package display_pkg;

   localparam logic [6:0] SEG_0       = 7'b1000000;
   localparam logic [6:0] SEG_1       = 7'b1111001;
   localparam logic [6:0] SEG_2       = 7'b0100100;
   localparam logic [6:0] SEG_3       = 7'b0110000;
   localparam logic [6:0] SEG_4       = 7'b0011001;
   localparam logic [6:0] SEG_5       = 7'b0010010;
   localparam logic [6:0] SEG_6       = 7'b0000010;
   localparam logic [6:0] SEG_7       = 7'b1111000;
   localparam logic [6:0] SEG_8       = 7'b0000000;
   localparam logic [6:0] SEG_9       = 7'b0010000;
   localparam logic [6:0] SEG_TRACO   = 7'b0111111;
   localparam logic [6:0] SEG_APAGADO = 7'b1111111;

   localparam logic [1:0] DIG_UNIDADE = 2'd0;
   localparam logic [1:0] DIG_DEZENA  = 2'd1;
   localparam logic [1:0] DIG_CENTENA = 2'd2;
   localparam logic [1:0] DIG_MILHAR  = 2'd3;

endpackage : display_pkg

// File: rtl/decodificador_7seg.sv
// ----------------------------------------------------------------------------
// decodificador_7seg
// Combinational BCD to seven-segment glyph decoder (active-low).
// Priority: dash flag, then non-decimal digit (dash), then blank, then glyph.
//   i_digito     : 4-bit BCD digit
//   i_apagar     : leading-zero blank request
//   i_traco      : force dash (overflow)
//   o_segmentos  : {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module decodificador_7seg
   import display_pkg::*;
(
   input  logic [3:0] i_digito,
   input  logic       i_apagar,
   input  logic       i_traco,
   output logic [6:0] o_segmentos
);

   logic [6:0] w_glifo;

   always_comb begin
      // NOTE: the default assignment before the case keeps this block free of
      // inferred latches for codes 10..15.
      w_glifo = SEG_TRACO;
      case (i_digito)
         4'd0:    w_glifo = SEG_0;
         4'd1:    w_glifo = SEG_1;
         4'd2:    w_glifo = SEG_2;
         4'd3:    w_glifo = SEG_3;
         4'd4:    w_glifo = SEG_4;
         4'd5:    w_glifo = SEG_5;
         4'd6:    w_glifo = SEG_6;
         4'd7:    w_glifo = SEG_7;
         4'd8:    w_glifo = SEG_8;
         4'd9:    w_glifo = SEG_9;
         default: w_glifo = SEG_TRACO;
      endcase
   end

   // Dash outranks blanking, so an invalid leading digit is still visible.
   always_comb begin
      if (i_traco || (i_digito > 4'd9)) begin
         o_segmentos = SEG_TRACO;
      end else if (i_apagar) begin
         o_segmentos = SEG_APAGADO;
      end else begin
         o_segmentos = w_glifo;
      end
   end

endmodule : decodificador_7seg

// File: rtl/multiplexador_display.sv
// ----------------------------------------------------------------------------
// multiplexador_display
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Captures BCD digits on a load strobe into shadow registers and scans them
// onto a shared segment bus with leading-zero blanking, overflow dashes,
// an anti-ghosting guard interval and a frame-sync pulse.
//   clock        : rising-edge clock
//   reset        : synchronous, active-high
//   carregar     : load strobe for digits and overflow
//   unidade..milhar : BCD digits
//   overflow     : value above 9999, shows dashes on every digit
//   segmentos    : {g,f,e,d,c,b,a}, active-low, registered
//   anodos       : bit0 = unidade .. bit3 = milhar, active-low, registered
//   quadro       : one-cycle pulse at the start of each scan frame
// ----------------------------------------------------------------------------
module multiplexador_display
   import display_pkg::*;
#(
   parameter int DIVISOR = 50000,
   parameter int GUARDA  = 16
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       carregar,
   input  logic [3:0] unidade,
   input  logic [3:0] dezena,
   input  logic [3:0] centena,
   input  logic [3:0] milhar,
   input  logic       overflow,
   output logic [6:0] segmentos,
   output logic [3:0] anodos,
   output logic       quadro
);

   localparam int             CW       = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
   localparam logic [CW-1:0]  L_ULTIMO = CW'(DIVISOR - 1);
   localparam logic [CW-1:0]  L_GUARDA = CW'(GUARDA);

   logic [CW-1:0] r_cont;
   logic [1:0]    r_indice;
   logic [3:0]    r_sombra [4];
   logic          r_ovf_s;

   logic [3:0]    w_digito;
   logic          w_apagar;
   logic [6:0]    w_glifo;

   // ---------------------------------------------------------------------
   // Prescaler, scan index and shadow registers
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cont   <= '0;
         r_indice <= DIG_UNIDADE;
         r_ovf_s  <= 1'b0;
         // NOTE: the four-entry shadow is plain flops, so it is cleared here;
         // after reset the display must show a defined "0", not garbage.
         for (int i = 0; i < 4; i++) r_sombra[i] <= '0;
      end else begin
         if (r_cont == L_ULTIMO) begin
            r_cont   <= '0;
            r_indice <= r_indice + 2'd1;
         end else begin
            r_cont <= r_cont + 1'b1;
         end

         if (carregar) begin
            r_sombra[DIG_UNIDADE] <= unidade;
            r_sombra[DIG_DEZENA]  <= dezena;
            r_sombra[DIG_CENTENA] <= centena;
            r_sombra[DIG_MILHAR]  <= milhar;
            r_ovf_s               <= overflow;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Leading-zero blanking for the currently selected digit
   // ---------------------------------------------------------------------
   assign w_digito = r_sombra[r_indice];

   always_comb begin
      w_apagar = 1'b0;
      case (r_indice)
         DIG_MILHAR:  w_apagar = (r_sombra[DIG_MILHAR] == 4'd0);
         DIG_CENTENA: w_apagar = (r_sombra[DIG_MILHAR] == 4'd0) &&
                                 (r_sombra[DIG_CENTENA] == 4'd0);
         DIG_DEZENA:  w_apagar = (r_sombra[DIG_MILHAR] == 4'd0) &&
                                 (r_sombra[DIG_CENTENA] == 4'd0) &&
                                 (r_sombra[DIG_DEZENA] == 4'd0);
         DIG_UNIDADE: w_apagar = 1'b0;   // a value of 0 still shows "0"
         default:     w_apagar = 1'b0;
      endcase
   end

   decodificador_7seg u_decodificador (
      .i_digito    (w_digito),
      .i_apagar    (w_apagar),
      .i_traco     (r_ovf_s),
      .o_segmentos (w_glifo)
   );

   // ---------------------------------------------------------------------
   // Output registers: one-cycle lag behind the scan state
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         segmentos <= SEG_APAGADO;
         anodos    <= 4'b1111;
         quadro    <= 1'b0;
      end else begin
         segmentos <= w_glifo;
         // Guard interval keeps all digits dark while the segment bus settles.
         anodos    <= (r_cont < L_GUARDA) ? 4'b1111 : ~(4'b0001 << r_indice);
         quadro    <= (r_cont == '0) && (r_indice == DIG_UNIDADE);
      end
   end

endmodule : multiplexador_display

// File: doc/multiplexador_display.md
# multiplexador_display

Time-multiplexed driver for a 4-digit common-anode seven-segment display. Sits directly downstream of the combinational binary-to-BCD converter: captures its `unidade`/`dezena`/`centena`/`milhar` digits on a load strobe and scans them onto one shared segment bus with per-digit anode enables. Adds leading-zero blanking, an overflow/invalid-digit dash pattern, an anti-ghosting guard interval and a frame-sync pulse.

## Interface
- `DIVISOR`, 50000: clock cycles each digit stays selected. Legal range is ≥ 2.
- `GUARDA`, 16: cycles at the start of each digit slot with all anodes off. Legal range is 0 ≤ GUARDA < DIVISOR.
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `carregar` in 1: load strobe. Digit inputs and `overflow` are sampled on any edge where this is high.
- `unidade`, `dezena`, `centena`, `milhar` in 4 each: BCD digits from the converter.
- `overflow` in 1: value exceeds 9999. When set, all four digits show a dash.
- `segmentos` out 7: {g,f,e,d,c,b,a}, active-low, registered.
- `anodos` out 4: bit0 = unidade … bit3 = milhar, active-low, registered.
- `quadro` out 1: one-cycle registered pulse at the start of each scan frame.

## Operation
- Shadow registers `sombra[0..3]` and `ovf_s`:
  - Loaded when `carregar` is high.
  - Otherwise hold.
  - The display never reads the inputs directly.
- Prescaler `cont`:
  - Counts 0 … DIVISOR-1, then wraps to 0.
  - On the wrap, `indice` (2 bits) increments mod 4: 0 = unidade, 1 = dezena, 2 = centena, 3 = milhar.
- Glyph for the selected digit, in priority order:
  1. `ovf_s` = 1 → dash (7'b0111111).
  2. Digit > 9 → dash.
  3. Leading-zero blanked → blank (7'b1111111).
  4. Otherwise the decimal glyph: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
- Leading-zero blanking:
  - milhar is blanked if 0.
  - centena is blanked if milhar and centena are both 0.
  - dezena is blanked if milhar, centena and dezena are all 0.
  - unidade is never blanked, so value 0 shows "0".
- Anodes:
  - All high (off) while `cont < GUARDA`.
  - Otherwise only bit `indice` is low.
- `quadro` is 1 exactly when `cont == 0` and `indice == 0`.

## Timing
- Reset values:
  - `segmentos` = 7'b1111111, `anodos` = 4'b1111, `quadro` = 0.
  - `cont` = 0, `indice` = 0, `sombra` = 0, `ovf_s` = 0.
- All outputs are registered functions of (`cont`, `indice`, `sombra`, `ovf_s`) sampled at the previous edge. Outputs lag the internal state by exactly one cycle.
- First edge after `reset` falls:
  - `quadro` = 1.
  - `anodos` = 1111 if GUARDA > 0, else 1110.
- Load latency:
  - `carregar` sampled at edge k → shadow updated at k.
  - New glyph visible on `segmentos` at edge k+1, if that digit is currently selected.
  - A load does not disturb `cont` or `indice`.
- `carregar` held high continuously makes the shadow track the inputs every cycle. This is legal.
- Scan period: each digit occupies DIVISOR cycles; one frame is 4·DIVISOR cycles. `quadro` period is 4·DIVISOR.
- `indice` wraps 3 → 0 when `cont` wraps.
- Reset asserted mid-slot or concurrently with `carregar`: reset wins and all state returns to reset values on that edge.

## Structure
- Shared package `display_pkg`:
  - segment glyph constants (`SEG_0` … `SEG_9`, `SEG_TRACO`, `SEG_APAGADO`)
  - digit index constants (`DIG_UNIDADE` … `DIG_MILHAR`)
- One combinational sub-module, `decodificador_7seg`: 4-bit digit, blank flag and dash flag in; 7-bit active-low glyph out.
- Counters, shadow registers, blanking logic and output registers live in the top module.

## Test plan
All scenarios use DIVISOR = 4, GUARDA = 1.

- **Reset:** hold `reset` 3 cycles.
  - During reset: `segmentos` = 1111111, `anodos` = 1111.
  - First edge after release: `quadro` = 1, `anodos` = 1111.
  - Next edge: `anodos` = 1110.
- **Load 1234** (milhar = 1 … unidade = 4), `carregar` pulsed once. Over one frame the selected `anodos` sequence is 1110, 1101, 1011, 0111 with `segmentos` 0011001, 0110000, 0100100, 1111001. Each digit is lit 3 cycles and preceded by 1 guard cycle.
- **Load 0007:** `segmentos` shows blank on the milhar, centena and dezena slots and 1111000 on unidade. Load 0000: only unidade shows 1000000.
- **Overflow = 1 with digits 1234:** all four slots show 0111111. Reload with overflow = 0 restores the normal digits on the next selected slot.
- **Invalid digit:** dezena = 4'hC shows 0111111 on the dezena slot only.
- **Mid-frame events:**
  - Reset asserted during the centena slot: outputs return to reset values on the next edge and the scan restarts at unidade.
  - `carregar` asserted in the same cycle as an `indice` wrap: the new value appears without skipping a slot.
